spi_tx_mlane: RTL and testbench
===============================

// Module: spi_tx_mlane
// PURPOSE
//  Parametrised SPI transmit shifter: single/dual/quad lanes, MSB- or LSB-first, WORD_W-bit words.
//  Sits between the APB register bank (data/length/mode) and the SPI pins. Advances on tx_edge_i strobes from the SCLK generator.
//  One-word holding buffer lets the CPU queue the next word during the current one. Multi-word bursts of arbitrary bit length.
// PARAMETERS
//  WORD_W     32  word width; must be a multiple of 4
//  LEN_W      16  width of the transfer-length (bit count) field
// PORTS
//  clk_i             in   1        system clock
//  rst_n_i           in   1        asynchronous active-low reset
//  en_i              in   1        enable; low during SHIFT aborts the transfer
//  tx_edge_i         in   1        one-cycle shift strobe from the SCLK generator
//  tx_mode_i         in   2        lane mode: 0 single, 1 dual, 2 quad, 3 reserved (treated as single)
//  tx_lsb_first_i    in   1        1 = LSB first, 0 = MSB first
//  tx_length_i       in   LEN_W    transfer length in bits
//  tx_length_updt_i  in   1        load tx_length_i into the length register
//  tx_data_i         in   WORD_W   word from the CPU
//  tx_data_vld_i     in   1        word valid
//  tx_data_rdy_o     out  1        hold buffer can accept a word
//  sdo_o             out  4        serial data lanes; lanes unused in the current mode drive 0
//  busy_o            out  1        FSM is in SHIFT
//  tx_done_o         out  1        pulses on the strobe that consumes the final beat
//  tx_underrun_o     out  1        underrun flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: sdo_o 0, tx_done_o 0, busy_o 0, tx_underrun_o 0, tx_data_rdy_o 1. All registers 0; hold buffer empty; FSM in IDLE.
//  Handshake: tx_data_rdy_o = ~hold_vld. A word is accepted when vld && rdy. It is never dropped.
//  FSM IDLE->SHIFT (go): en_i && hold_vld && len_reg != 0.
//   On go: shifter <= hold, hold emptied, bit_cnt <= 0.
//   On go: tx_mode_i, tx_lsb_first_i and len_reg are latched into active copies.
//   Mid-transfer changes to tx_mode_i, tx_lsb_first_i or tx_length_i affect only the next transfer.
//  SHIFT: lanes L = 1/2/4. The current beat is presented combinationally from the shifter.
//   MSB-first: sdo[L-1:0] = shifter[W-1 -: L].
//   LSB-first: sdo[L-1:0] = shifter[L-1:0].
//   Each tx_edge_i strobe shifts the shifter by L bits and does bit_cnt += L.
//  Word boundary (strobe consumes the last beat of a word, not the final beat):
//   - If hold_vld: reload the shifter from hold.
//   - If hold is empty but vld&&rdy in the same cycle: bypass tx_data_i straight into the shifter.
//   - Otherwise: underrun. Return to IDLE; no tx_done_o.
//  Final beat: bit_cnt + L >= len_act (LEN_W+1-bit compare).
//   tx_done_o pulses 1 cycle with that strobe; next state IDLE.
//   A length that is not a multiple of L is rounded up to the next beat; surplus bits are don't-care.
//  en_i low in SHIFT: IDLE next cycle, no tx_done_o, bit_cnt cleared, hold contents kept.
//  Reset mid-operation: all state returns to reset values asynchronously.
//  busy_o = (state == SHIFT).
// CONFIGURATION
//  Macro: SPI_TX_UNDERRUN_EN.
//  Defined: tx_underrun_o is sticky. It is set on an underrun exit and cleared by tx_length_updt_i or by the next go. If both happen in the same cycle, set wins.
//  Undefined: tx_underrun_o is tied to 0. The underrun exit to IDLE still occurs.
// STRUCTURE
//  Package spi_tx_pkg:
//   - typedef enum logic [1:0] {LANE_X1, LANE_X2, LANE_X4} lane_mode_e
//   - typedef enum logic {IDLE, SHIFT} tx_state_e
//   - function lanes(lane_mode_e) returning 1/2/4
//  Sub-module spi_tx_hold: one-entry valid/ready holding register with bypass output.
//  FSM, counter, shifter and lane muxing stay in this module.
// TESTING
//  1 Single, MSB, len 32, data 0xA5000001, edge every 4 clk -> sdo_o[0] = 1,0,1,0,0,1,0,1,...,1; tx_done_o on strobe 32; sdo_o[3:1] = 0.
//  2 Quad, LSB, len 64, words 0x76543210 then 0xFEDCBA98 queued mid-word -> nibbles 0..F on sdo_o in order; one tx_done_o; rdy high again after the boundary.
//  3 Dual, MSB, len 40, only one word supplied -> exit to IDLE after 16 strobes; no tx_done_o; tx_underrun_o = 1 iff SPI_TX_UNDERRUN_EN.
//  4 Hold empty at word boundary with vld raised in that same cycle -> bypass; no gap and no underrun; 64-bit burst completes.
//  5 en_i dropped after 5 strobes -> busy_o 0 next cycle; no tx_done_o; a restart sends from a fresh word with bit_cnt 0.
//  6 Single, len 3 -> exactly 3 strobes, then tx_done_o; len_reg 0 with vld -> stays IDLE.

Source files
------------

// File: rtl/spi_tx_pkg.sv
// Shared types for the multi-lane SPI transmit shifter.
package spi_tx_pkg;

    typedef enum logic [1:0] {LANE_X1, LANE_X2, LANE_X4} lane_mode_e;

    typedef enum logic {IDLE, SHIFT} tx_state_e;

    function automatic logic [2:0] lanes(lane_mode_e mode);
        case (mode)
            LANE_X2: return 3'd2;
            LANE_X4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_hold.sv
// One-entry valid/ready holding register; out_* presents the held word, or the
// incoming word when empty so the shifter can take it in the same cycle.
module spi_tx_hold #(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic              take_i,
    output logic              hold_vld_o,
    output logic              out_vld_o,
    output logic [WORD_W-1:0] out_data_o
);

    logic              vld_q, vld_d;
    logic [WORD_W-1:0] data_q, data_d;

    // A take while empty consumes the incoming word directly (bypass), so it is not stored.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (take_i && vld_q) begin
            vld_d = 1'b0;
        end else if (vld_i && !vld_q && !take_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= 1'b0;
            // NOTE: the data word is reset as well; it is a single register, not a RAM.
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign rdy_o      = ~vld_q;
    assign hold_vld_o = vld_q;
    assign out_vld_o  = vld_q | vld_i;
    assign out_data_o = vld_q ? data_q : data_i;

endmodule

// File: rtl/spi_tx_mlane.sv
// Single/dual/quad SPI transmit shifter with a one-word holding buffer.
// Define SPI_TX_UNDERRUN_EN to make tx_underrun_o a sticky underrun flag.
module spi_tx_mlane
    import spi_tx_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              tx_edge_i,
    input  logic [1:0]        tx_mode_i,
    input  logic              tx_lsb_first_i,
    input  logic [LEN_W-1:0]  tx_length_i,
    input  logic              tx_length_updt_i,
    input  logic [WORD_W-1:0] tx_data_i,
    input  logic              tx_data_vld_i,
    output logic              tx_data_rdy_o,
    output logic [3:0]        sdo_o,
    output logic              busy_o,
    output logic              tx_done_o,
    output logic              tx_underrun_o
);

    localparam int WCNT_W = $clog2(WORD_W) + 1;
    localparam int CMP_W  = LEN_W + 1;

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shifter_q, shifter_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [LEN_W-1:0]  len_reg_q, len_reg_d;
    logic [LEN_W-1:0]  len_act_q, len_act_d;
    lane_mode_e        mode_act_q, mode_act_d;
    logic              lsb_act_q, lsb_act_d;

    lane_mode_e        mode_in;
    logic [2:0]        lane_n;
    logic              hold_vld, buf_vld, take;
    logic [WORD_W-1:0] buf_data;
    logic              go, strobe, final_beat, word_end, underrun_exit;

    spi_tx_hold #(.WORD_W(WORD_W)) u_hold (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .data_i     (tx_data_i),
        .vld_i      (tx_data_vld_i),
        .rdy_o      (tx_data_rdy_o),
        .take_i     (take),
        .hold_vld_o (hold_vld),
        .out_vld_o  (buf_vld),
        .out_data_o (buf_data)
    );

    // Reserved mode 3 falls back to single lane.
    always_comb begin
        case (tx_mode_i)
            2'd1:    mode_in = LANE_X2;
            2'd2:    mode_in = LANE_X4;
            default: mode_in = LANE_X1;
        endcase
    end

    assign lane_n        = lanes(mode_act_q);
    assign go            = (state_q == IDLE) && en_i && hold_vld && (len_reg_q != '0);
    assign strobe        = (state_q == SHIFT) && en_i && tx_edge_i;
    assign final_beat    = ({1'b0, bit_cnt_q} + CMP_W'(lane_n)) >= {1'b0, len_act_q};
    assign word_end      = (wcnt_q + WCNT_W'(lane_n)) >= WCNT_W'(WORD_W);
    assign underrun_exit = strobe && !final_beat && word_end && !buf_vld;
    assign take          = go || (strobe && !final_beat && word_end && buf_vld);

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can infer a latch.
        state_d    = state_q;
        shifter_d  = shifter_q;
        bit_cnt_d  = bit_cnt_q;
        wcnt_d     = wcnt_q;
        len_reg_d  = tx_length_updt_i ? tx_length_i : len_reg_q;
        len_act_d  = len_act_q;
        mode_act_d = mode_act_q;
        lsb_act_d  = lsb_act_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = SHIFT;
                    shifter_d  = buf_data;
                    bit_cnt_d  = '0;
                    wcnt_d     = '0;
                    len_act_d  = len_reg_q;
                    mode_act_d = mode_in;
                    lsb_act_d  = tx_lsb_first_i;
                end
            end
            SHIFT: begin
                if (!en_i) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    wcnt_d    = '0;
                end else if (tx_edge_i) begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(lane_n);
                    wcnt_d    = wcnt_q + WCNT_W'(lane_n);
                    shifter_d = lsb_act_q ? (shifter_q >> lane_n) : (shifter_q << lane_n);
                    if (final_beat || underrun_exit) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else if (word_end) begin
                        wcnt_d    = '0;
                        shifter_d = buf_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            shifter_q  <= '0;
            bit_cnt_q  <= '0;
            wcnt_q     <= '0;
            len_reg_q  <= '0;
            len_act_q  <= '0;
            mode_act_q <= LANE_X1;
            lsb_act_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q    <= state_d;
            shifter_q  <= shifter_d;
            bit_cnt_q  <= bit_cnt_d;
            wcnt_q     <= wcnt_d;
            len_reg_q  <= len_reg_d;
            len_act_q  <= len_act_d;
            mode_act_q <= mode_act_d;
            lsb_act_q  <= lsb_act_d;
        end
    end

    // Current beat; lanes unused in this mode and the idle bus drive 0.
    always_comb begin
        sdo_o = '0;
        if (state_q == SHIFT) begin
            case (mode_act_q)
                LANE_X2: sdo_o[1:0] = lsb_act_q ? shifter_q[1:0] : shifter_q[WORD_W-1 -: 2];
                LANE_X4: sdo_o      = lsb_act_q ? shifter_q[3:0] : shifter_q[WORD_W-1 -: 4];
                default: sdo_o[0]   = lsb_act_q ? shifter_q[0]   : shifter_q[WORD_W-1];
            endcase
        end
    end

    assign busy_o    = (state_q == SHIFT);
    assign tx_done_o = strobe && final_beat;

`ifdef SPI_TX_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (tx_length_updt_i || go) underrun_d = 1'b0;
        if (underrun_exit)          underrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) underrun_q <= 1'b0;
        else          underrun_q <= underrun_d;
    end

    assign tx_underrun_o = underrun_q;
`else
    assign tx_underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_mlane.sv
// Directed self-checking bench for spi_tx_mlane (default 32-bit words, 16-bit length).
module tb_spi_tx_mlane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        tx_edge_i;
    logic [1:0]  tx_mode_i;
    logic        tx_lsb_first_i;
    logic [15:0] tx_length_i;
    logic        tx_length_updt_i;
    logic [31:0] tx_data_i;
    logic        tx_data_vld_i;
    logic        tx_data_rdy_o;
    logic [3:0]  sdo_o;
    logic        busy_o;
    logic        tx_done_o;
    logic        tx_underrun_o;

    int n_pass  = 0;
    int n_total = 0;

`ifdef SPI_TX_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    spi_tx_mlane dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .en_i             (en_i),
        .tx_edge_i        (tx_edge_i),
        .tx_mode_i        (tx_mode_i),
        .tx_lsb_first_i   (tx_lsb_first_i),
        .tx_length_i      (tx_length_i),
        .tx_length_updt_i (tx_length_updt_i),
        .tx_data_i        (tx_data_i),
        .tx_data_vld_i    (tx_data_vld_i),
        .tx_data_rdy_o    (tx_data_rdy_o),
        .sdo_o            (sdo_o),
        .busy_o           (busy_o),
        .tx_done_o        (tx_done_o),
        .tx_underrun_o    (tx_underrun_o)
    );

    always #5 clk = ~clk;

    // Called at a negedge: raise the strobe, sample the beat, drop strobe and vld, idle out the gap.
    task automatic strobe(input int gap, output logic [3:0] s, output logic d);
        tx_edge_i = 1'b1;
        #1;
        s = sdo_o;
        d = tx_done_o;
        @(negedge clk);
        tx_edge_i     = 1'b0;
        tx_data_vld_i = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Loads length and the first word; returns at the negedge after go.
    task automatic load(input logic [1:0] mode, input logic lsb, input logic [15:0] len,
                        input logic [31:0] data);
        tx_mode_i        = mode;
        tx_lsb_first_i   = lsb;
        tx_length_i      = len;
        tx_length_updt_i = 1'b1;
        tx_data_i        = data;
        tx_data_vld_i    = 1'b1;
        @(negedge clk);
        tx_length_updt_i = 1'b0;
        tx_data_vld_i    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        en_i             = 1'b1;
        tx_edge_i        = 1'b0;
        tx_mode_i        = 2'd0;
        tx_lsb_first_i   = 1'b0;
        tx_length_i      = '0;
        tx_length_updt_i = 1'b0;
        tx_data_i        = '0;
        tx_data_vld_i    = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({sdo_o, tx_done_o, busy_o, tx_underrun_o, tx_data_rdy_o} !== 8'b0000_0001)
            $display("FAIL reset_outputs: got %b expected %b",
                     {sdo_o, tx_done_o, busy_o, tx_underrun_o, tx_data_rdy_o}, 8'b0000_0001);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy_o, tx_data_rdy_o} !== 2'b01)
            $display("FAIL post_reset_idle: got %b expected 01", {busy_o, tx_data_rdy_o});
        else n_pass++;
    endtask

    task automatic test_single_msb;
        logic [31:0] w;
        logic [3:0]  s;
        logic        d;
        w = 32'hA500_0001;
        load(2'd0, 1'b0, 16'd32, w);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL x1_start_busy: got %b expected 1", busy_o);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            strobe(4, s, d);
            n_total++;
            if ({s, d} !== {3'b000, w[31-i], (i == 31)})
                $display("FAIL x1_msb_beat%0d: got sdo=%b done=%b expected sdo=%b done=%b",
                         i, s, d, {3'b000, w[31-i]}, (i == 31));
            else n_pass++;
        end
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL x1_end_busy: got %b expected 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_quad_lsb_queue;
        logic [3:0] s;
        logic       d;
        load(2'd2, 1'b1, 16'd64, 32'h7654_3210);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL x4_start_busy: got %b expected 1", busy_o);
        else n_pass++;
        // These must not disturb the transfer already running.
        tx_mode_i      = 2'd0;
        tx_lsb_first_i = 1'b0;
        tx_length_i    = 16'd8;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                n_total++;
                if (tx_data_rdy_o !== 1'b1) $display("FAIL x4_rdy_before_queue: got %b expected 1", tx_data_rdy_o);
                else n_pass++;
                tx_data_i     = 32'hFEDC_BA98;
                tx_data_vld_i = 1'b1;
            end
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {4'(i), (i == 15)})
                $display("FAIL x4_lsb_beat%0d: got sdo=%h done=%b expected sdo=%h done=%b",
                         i, s, d, 4'(i), (i == 15));
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (tx_data_rdy_o !== 1'b0) $display("FAIL x4_rdy_while_held: got %b expected 0", tx_data_rdy_o);
                else n_pass++;
            end
            if (i == 7) begin
                n_total++;
                if ({busy_o, tx_data_rdy_o} !== 2'b11)
                    $display("FAIL x4_after_boundary: got busy/rdy=%b expected 11", {busy_o, tx_data_rdy_o});
                else n_pass++;
            end
        end
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL x4_end_busy: got %b expected 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_dual_underrun;
        logic [31:0] w;
        logic [1:0]  e;
        logic [3:0]  s;
        logic        d;
        w = 32'hC3A5_5A3C;
        load(2'd1, 1'b0, 16'd40, w);
        for (int i = 0; i < 16; i++) begin
            e = w[31:30];
            w = w << 2;
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {2'b00, e, 1'b0})
                $display("FAIL x2_beat%0d: got sdo=%b done=%b expected sdo=%b done=0", i, s, d, {2'b00, e});
            else n_pass++;
            if (i == 14) begin
                n_total++;
                if (busy_o !== 1'b1) $display("FAIL x2_busy_before_boundary: got %b expected 1", busy_o);
                else n_pass++;
            end
        end
        n_total++;
        if ({busy_o, tx_underrun_o} !== {1'b0, UR_EXP})
            $display("FAIL x2_underrun_exit: got busy/ur=%b expected %b", {busy_o, tx_underrun_o}, {1'b0, UR_EXP});
        else n_pass++;
        tx_length_updt_i = 1'b1;
        @(negedge clk);
        tx_length_updt_i = 1'b0;
        n_total++;
        if (tx_underrun_o !== 1'b0) $display("FAIL x2_underrun_clear: got %b expected 0", tx_underrun_o);
        else n_pass++;
    endtask

    task automatic test_bypass;
        logic [3:0] s;
        logic       d;
        load(2'd2, 1'b0, 16'd64, 32'h0123_4567);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                n_total++;
                if (tx_data_rdy_o !== 1'b1) $display("FAIL bypass_rdy_at_boundary: got %b expected 1", tx_data_rdy_o);
                else n_pass++;
                tx_data_i     = 32'h89AB_CDEF;
                tx_data_vld_i = 1'b1;
            end
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {4'(i), (i == 15)})
                $display("FAIL bypass_beat%0d: got sdo=%h done=%b expected sdo=%h done=%b",
                         i, s, d, 4'(i), (i == 15));
            else n_pass++;
            if (i == 7) begin
                n_total++;
                if ({busy_o, tx_data_rdy_o, tx_underrun_o} !== 3'b110)
                    $display("FAIL bypass_after_boundary: got busy/rdy/ur=%b expected 110",
                             {busy_o, tx_data_rdy_o, tx_underrun_o});
                else n_pass++;
            end
        end
        n_total++;
        if ({busy_o, tx_underrun_o} !== 2'b00)
            $display("FAIL bypass_end: got busy/ur=%b expected 00", {busy_o, tx_underrun_o});
        else n_pass++;
    endtask

    task automatic test_abort_restart;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        logic        d;
        a = 32'hF0F0_F0F0;
        b = 32'h8000_0001;
        load(2'd0, 1'b0, 16'd32, a);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                tx_data_i     = b;
                tx_data_vld_i = 1'b1;
            end
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {3'b000, a[31-i], 1'b0})
                $display("FAIL abort_beat%0d: got sdo=%b done=%b expected sdo=%b done=0", i, s, d, {3'b000, a[31-i]});
            else n_pass++;
        end
        en_i = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy_o, tx_done_o, tx_data_rdy_o} !== 3'b000)
            $display("FAIL abort_idle: got busy/done/rdy=%b expected 000", {busy_o, tx_done_o, tx_data_rdy_o});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL abort_stays_idle: got %b expected 0", busy_o);
        else n_pass++;
        en_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL restart_busy: got %b expected 1", busy_o);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {3'b000, b[31-i], (i == 31)})
                $display("FAIL restart_beat%0d: got sdo=%b done=%b expected sdo=%b done=%b",
                         i, s, d, {3'b000, b[31-i]}, (i == 31));
            else n_pass++;
        end
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL restart_end_busy: got %b expected 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_short_and_zero_len;
        logic [31:0] w;
        logic [3:0]  s;
        logic        d;
        w = 32'hA000_0000;
        load(2'd0, 1'b0, 16'd3, w);
        for (int i = 0; i < 3; i++) begin
            strobe(2, s, d);
            n_total++;
            if ({s, d} !== {3'b000, w[31-i], (i == 2)})
                $display("FAIL len3_beat%0d: got sdo=%b done=%b expected sdo=%b done=%b",
                         i, s, d, {3'b000, w[31-i]}, (i == 2));
            else n_pass++;
        end
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL len3_end_busy: got %b expected 0", busy_o);
        else n_pass++;
        load(2'd0, 1'b0, 16'd0, 32'h1234_5678);
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy_o, tx_data_rdy_o, sdo_o} !== 6'b000000)
            $display("FAIL len0_stays_idle: got busy/rdy/sdo=%b expected 000000", {busy_o, tx_data_rdy_o, sdo_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid_transfer;
        tx_mode_i        = 2'd2;
        tx_length_i      = 16'd32;
        tx_length_updt_i = 1'b1;
        @(negedge clk);
        tx_length_updt_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL midreset_start_busy: got %b expected 1", busy_o);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({sdo_o, busy_o, tx_data_rdy_o, tx_underrun_o} !== 7'b0000_010)
            $display("FAIL midreset_outputs: got %b expected 0000010",
                     {sdo_o, busy_o, tx_data_rdy_o, tx_underrun_o});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_quad_lsb_queue();
        test_dual_underrun();
        test_bypass();
        test_abort_restart();
        test_short_and_zero_len();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
